// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder on an internal word RAM.
// Byte/half/word accesses with programmable wait and error reporting.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_memrw,
    input  logic [1:0]  req_access_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          memrw_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          bad;
    logic          accept;
    logic          access;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ldata;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    assign req_ready = (state == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign off       = req_addr - ADDR_BASE;
    assign access    = (state == S_WAIT) && (cnt == 4'd0);
    assign word      = mem[idx_q];

    // reject reserved size, misalignment and out-of-window addresses
    always_comb begin
        bad = (off >= SPAN);
        case (req_access_size)
            2'b00:   bad = bad;
            2'b01:   bad = bad || req_addr[0];
            2'b10:   bad = bad || (req_addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    // lane select and extension of the loaded word
    always_comb begin
        case (lane_q)
            2'd0:    bsel = word[7:0];
            2'd1:    bsel = word[15:8];
            2'd2:    bsel = word[23:16];
            default: bsel = word[31:24];
        endcase
        hsel = lane_q[1] ? word[31:16] : word[15:0];
        case (size_q)
            2'b00:   ldata = uns_q ? {24'b0, bsel}
                                   : {{24{bsel[7]}}, bsel};
            2'b01:   ldata = uns_q ? {16'b0, hsel}
                                   : {{16{hsel[15]}}, hsel};
            default: ldata = word;
        endcase
    end

    // byte enables and replicated store data per access size
    always_comb begin
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << lane_q;
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = lane_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
        endcase
    end

    // RAM write on the access edge; contents survive reset
    always_ff @(posedge clock) begin
        if (access && memrw_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // request latch, wait countdown and response generation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            memrw_q   <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            lane_q    <= 2'b00;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (accept) begin
                        memrw_q <= req_memrw;
                        size_q  <= req_access_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        idx_q   <= off[AW+1:2];
                        wdata_q <= req_wdata;
                        if (bad) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                (state == S_WAIT): begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= memrw_q ? 32'd0 : ldata;
                    end
                end
                (state == S_RESP): begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
